conv_kernel_scheduler: RTL and testbench

CONV_KERNEL_SCHEDULER -- requirements
Module: conv_kernel_scheduler

---
 rtl/conv_kernel_scheduler.sv | 130 +++++++++++++
 tb/tb_conv_kernel_scheduler.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_kernel_scheduler.sv
// Multi-bank convolution kernel store with frame-aligned bank switching.
// The kernel driving the filter only changes at a frame boundary.
module conv_kernel_scheduler #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int KERNEL_H   = 3,
  parameter int KERNEL_W   = 3,
  parameter int W          = 8,
  parameter int W_FRAC     = 0,
  parameter int NUM_BANKS  = 4,
  localparam int BW = $clog2(NUM_BANKS),
  localparam int NT = KERNEL_H * KERNEL_W,
  localparam int IW = $clog2(NT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [BW-1:0] cfg_bank,
  input  logic [IW-1:0] cfg_idx,
  input  logic [W-1:0]  cfg_coef,
  output logic          cfg_err,
  input  logic          sel_valid,
  output logic          sel_ready,
  input  logic [BW-1:0] sel_bank,
  input  logic          pix_hs,
  output logic [KERNEL_H-1:0][KERNEL_W-1:0][W-1:0] kernel,
  output logic [BW-1:0] active_bank,
  output logic          pending,
  output logic          frame_done
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] XMAX = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] YMAX = YW'(IMG_HEIGHT - 1);
  localparam logic [IW:0]   NTV  = (IW + 1)'(NT);
  localparam int CTR = (KERNEL_H / 2) * KERNEL_W + KERNEL_W / 2;
  localparam logic [W-1:0]  ONE  = W'(1 << W_FRAC);
  localparam logic [NT*W-1:0] IDENT =
    {{(NT*W-W){1'b0}}, ONE} << (CTR * W);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    APPLY
  } state_e;

  state_e state_q;

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [BW-1:0] pend_q;
  logic [BW-1:0] act_q;
  logic          frame_done_q;
  logic          cfg_err_q;
  logic [NUM_BANKS-1:0][NT-1:0][W-1:0] bank_q;
  logic [KERNEL_H-1:0][KERNEL_W-1:0][W-1:0] kernel_q;

  logic last_hs;
  logic at_origin;
  logic cfg_drop;

  assign last_hs   = pix_hs && (x_q == XMAX) && (y_q == YMAX);
  assign at_origin = (x_q == '0) && (y_q == '0) && !pix_hs;

  // Never touch the bank on screen or the one about to go on screen.
  assign cfg_drop = (cfg_bank == act_q)
                 || ((state_q != IDLE) && (cfg_bank == pend_q))
                 || ({1'b0, cfg_idx} >= NTV);

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q          <= '0;
      y_q          <= '0;
      state_q      <= IDLE;
      pend_q       <= '0;
      act_q        <= '0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      bank_q       <= {NUM_BANKS{IDENT}};
      kernel_q     <= IDENT;
    end else begin
      if (pix_hs) begin
        if (x_q == XMAX) begin
          x_q <= '0;
          y_q <= (y_q == YMAX) ? '0 : y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
      frame_done_q <= last_hs;
      cfg_err_q    <= cfg_valid && cfg_drop;
      if (cfg_valid && !cfg_drop) begin
        bank_q[cfg_bank][cfg_idx] <= cfg_coef;
      end
      unique case (state_q)
        IDLE: begin
          if (sel_valid) begin
            pend_q  <= sel_bank;
            state_q <= (at_origin || last_hs) ? APPLY : ARMED;
          end
        end
        ARMED: begin
          if (sel_valid) begin
            pend_q <= sel_bank;
          end
          if (last_hs) begin
            state_q <= APPLY;
          end
        end
        APPLY: begin
          act_q    <= pend_q;
          kernel_q <= bank_q[pend_q];
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg_ready   = 1'b1;
  assign cfg_err     = cfg_err_q;
  assign sel_ready   = (state_q != APPLY);
  assign pending     = (state_q == ARMED);
  assign active_bank = act_q;
  assign frame_done  = frame_done_q;
  assign kernel      = kernel_q;

endmodule

// File: tb/tb_conv_kernel_scheduler.sv
// Bench for conv_kernel_scheduler: reference model tracks pixel index,
// requested bank and bank contents; outputs compared every cycle.
module tb_conv_kernel_scheduler;

  localparam int IMW = 32;
  localparam int IMH = 24;
  localparam int NP  = IMW * IMH;
  localparam int NT  = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_bank = '0;
  logic [3:0] cfg_idx = '0;
  logic [7:0] cfg_coef = '0;
  logic       cfg_err;
  logic       sel_valid = 1'b0;
  logic       sel_ready;
  logic [1:0] sel_bank = '0;
  logic       pix_hs = 1'b0;
  logic [2:0][2:0][7:0] kernel;
  logic [1:0] active_bank;
  logic       pending;
  logic       frame_done;

  conv_kernel_scheduler #(
    .IMG_WIDTH (IMW),
    .IMG_HEIGHT(IMH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_bank   (cfg_bank),
    .cfg_idx    (cfg_idx),
    .cfg_coef   (cfg_coef),
    .cfg_err    (cfg_err),
    .sel_valid  (sel_valid),
    .sel_ready  (sel_ready),
    .sel_bank   (sel_bank),
    .pix_hs     (pix_hs),
    .kernel     (kernel),
    .active_bank(active_bank),
    .pending    (pending),
    .frame_done (frame_done)
  );

  int npass = 0;
  int ntot  = 0;
  int nprint = 0;
  bit chk_en = 1'b0;
  int fd_cnt = 0;
  bit saw2 = 1'b0;

  int mb[4][NT];
  int mk[NT];
  int mact, mreq, mp;
  bit mhas, mapp, mdone, merr;

  task automatic model_step();
    bit last, drop, was;
    if (rst) begin
      mp = 0; mact = 0; mreq = 0;
      mhas = 0; mapp = 0; mdone = 0; merr = 0;
      for (int b = 0; b < 4; b++)
        for (int i = 0; i < NT; i++) mb[b][i] = (i == 4) ? 1 : 0;
      for (int i = 0; i < NT; i++) mk[i] = (i == 4) ? 1 : 0;
      return;
    end
    last = pix_hs && (mp == NP - 1);
    drop = (int'(cfg_bank) == mact) || (mhas && int'(cfg_bank) == mreq)
        || (int'(cfg_idx) >= NT);
    merr = cfg_valid && drop;
    if (cfg_valid && !drop) mb[cfg_bank][cfg_idx] = int'($signed(cfg_coef));
    mdone = last;
    if (mapp) begin
      mact = mreq;
      for (int i = 0; i < NT; i++) mk[i] = mb[mreq][i];
      mapp = 0;
      mhas = 0;
    end else begin
      was = mhas;
      if (sel_valid) begin
        mreq = sel_bank;
        mhas = 1;
      end
      if (mhas && (last || (!was && mp == 0 && !pix_hs))) mapp = 1;
    end
    if (pix_hs) mp = (mp == NP - 1) ? 0 : mp + 1;
  endtask

  task automatic report(string nm, int got, int want);
    if (nprint < 40) $display("FAIL %s: got %0d want %0d", nm, got, want);
    nprint++;
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      bit ok;
      ok = 1;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          if (kernel[r][c] !== 8'(mk[r*3+c])) begin
            ok = 0;
            report($sformatf("cyc_kernel_%0d%0d", r, c),
                   int'($signed(kernel[r][c])), mk[r*3+c]);
          end
      if (active_bank !== 2'(mact)) begin
        ok = 0; report("cyc_active", int'(active_bank), mact);
      end
      if (pending !== (mhas && !mapp)) begin
        ok = 0; report("cyc_pending", int'(pending), int'(mhas && !mapp));
      end
      if (frame_done !== mdone) begin
        ok = 0; report("cyc_frame_done", int'(frame_done), int'(mdone));
      end
      if (cfg_err !== merr) begin
        ok = 0; report("cyc_cfg_err", int'(cfg_err), int'(merr));
      end
      if (sel_ready !== !mapp) begin
        ok = 0; report("cyc_sel_ready", int'(sel_ready), int'(!mapp));
      end
      if (cfg_ready !== 1'b1) begin
        ok = 0; report("cyc_cfg_ready", int'(cfg_ready), 1);
      end
      ntot++;
      if (ok) npass++;
      if (frame_done === 1'b1) fd_cnt++;
      if (kernel[1][1] === 8'd2) saw2 = 1'b1;
    end
  end

  task automatic chk(string nm, int got, int want);
    ntot++;
    if (got == want) npass++;
    else $display("FAIL %s: got %0d want %0d", nm, got, want);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) cyc();
  endtask

  task automatic wr(int b, int i, int v);
    cfg_valid = 1'b1;
    cfg_bank  = 2'(b);
    cfg_idx   = 4'(i);
    cfg_coef  = 8'(v);
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic lap(int b);
    for (int i = 0; i < NT; i++) wr(b, i, (i == 4) ? 8 : -1);
  endtask

  task automatic fill(int b, int v);
    for (int i = 0; i < NT; i++) wr(b, i, v);
  endtask

  task automatic px(int n, bit gap);
    int h, k;
    h = 0;
    k = 0;
    while (h < n) begin
      pix_hs = gap ? (k % 3 != 2) : 1'b1;
      if (pix_hs) h++;
      k++;
      cyc();
    end
    pix_hs = 1'b0;
  endtask

  task automatic selpx(int b);
    pix_hs = 1'b1;
    sel_valid = 1'b1;
    sel_bank = 2'(b);
    cyc();
    pix_hs = 1'b0;
    sel_valid = 1'b0;
  endtask

  function automatic int kc(int r, int c);
    return int'($signed(kernel[r][c]));
  endfunction

  initial begin
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_centre", kc(1, 1), 1);
    chk("rst_corner", kc(0, 0), 0);
    chk("rst_active", int'(active_bank), 0);
    chk("rst_pending", int'(pending), 0);

    px(NP, 1'b0);
    idle(1);
    chk("f1_fd_once", fd_cnt, 1);
    chk("f1_centre", kc(1, 1), 1);

    lap(1);
    px(100, 1'b0);
    selpx(1);
    px(100, 1'b0);
    chk("lap_pending_mid", int'(pending), 1);
    chk("lap_active_mid", int'(active_bank), 0);
    px(NP - 201, 1'b0);
    chk("lap_hold_in_apply", kc(1, 1), 1);
    chk("lap_fd", int'(frame_done), 1);
    idle(1);
    chk("lap_centre", kc(1, 1), 8);
    chk("lap_corner", kc(0, 0), -1);
    chk("lap_active", int'(active_bank), 1);
    chk("lap_model_pin", mk[4], 8);

    fill(2, 2);
    fill(3, 3);
    px(50, 1'b1);
    selpx(2);
    px(250, 1'b1);
    selpx(3);
    chk("dbl_pending", int'(pending), 1);
    px(NP - 302, 1'b1);
    idle(1);
    chk("dbl_active", int'(active_bank), 3);
    chk("dbl_tap", kc(0, 0), 3);
    chk("dbl_never_b2", int'(saw2), 0);

    wr(3, 0, 5);
    chk("err_active_bank", int'(cfg_err), 1);
    wr(1, 9, 5);
    chk("err_idx9", int'(cfg_err), 1);
    wr(0, 0, 7);
    chk("ok_write", int'(cfg_err), 0);
    chk("err_kernel_same", kc(0, 0), 3);
    px(10, 1'b0);
    selpx(2);
    wr(2, 0, 9);
    chk("err_pend_bank", int'(cfg_err), 1);
    chk("arm_pending", int'(pending), 1);

    px(489, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_pending", int'(pending), 0);
    chk("mid_rst_active", int'(active_bank), 0);
    chk("mid_rst_centre", kc(1, 1), 1);
    chk("mid_rst_corner", kc(0, 0), 0);
    idle(1);
    px(NP, 1'b0);
    chk("mid_rst_fd", int'(frame_done), 1);
    idle(1);

    px(10, 1'b0);
    selpx(2);
    px(NP - 12, 1'b0);
    selpx(3);
    idle(2);
    chk("last_sel_active", int'(active_bank), 3);
    chk("last_sel_pending", int'(pending), 0);

    lap(1);
    sel_valid = 1'b1;
    sel_bank = 2'd1;
    cyc();
    sel_valid = 1'b0;
    chk("idle_apply_rdy", int'(sel_ready), 0);
    chk("idle_apply_pend", int'(pending), 0);
    cyc();
    chk("idle_active", int'(active_bank), 1);
    chk("idle_centre", kc(1, 1), 8);
    idle(2);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
